// File: rtl/fp_pkg.sv
// Shared float-pipe constants and record types.
// Default widths and the 1.5 encoding used by the subtractor.
package fp_pkg;

   localparam int EXP_W_D = 8;
   localparam int MAN_W_D = 23;
   localparam int GRD_W_D = 3;
   localparam int DLY_W_D = 31;
   localparam int BIAS_D  = (1 << (EXP_W_D - 1)) - 1;

   localparam logic [EXP_W_D-1:0] C_EXP_D = EXP_W_D'(BIAS_D);
   localparam logic [MAN_W_D-1:0] C_MAN_D = 23'h400000;

   typedef struct packed {
      logic [EXP_W_D-1:0] exp;
      logic [MAN_W_D-1:0] man;
   } fp_op_t;

   typedef struct packed {
      logic [MAN_W_D+GRD_W_D:0] d;
      logic                     sp_flag;
      logic                     err;
      logic                     ein;
      logic [EXP_W_D-1:0]       exp;
      logic [DLY_W_D-1:0]       dly;
   } fp_s1_t;

endpackage

// File: rtl/fp_norm_round.sv
// Leading-zero normalise, round and pack of an unsigned significand.
// Rounds to nearest-even when FP_CSUB_RNE_EN is defined, else truncates.
module fp_norm_round
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_D,
   parameter int MAN_W = MAN_W_D,
   parameter int GRD_W = GRD_W_D
) (
   input  logic [MAN_W+GRD_W:0]     d,
   input  logic [EXP_W-1:0]         exp_in,
   input  logic                     kill,
   output logic [EXP_W+MAN_W-1:0]   res
);

   localparam int W   = MAN_W + GRD_W + 1;
   localparam int LZW = $clog2(W + 1);

   logic [LZW-1:0]          lzc;
   logic [W-1:0]            n;
   logic signed [EXP_W+1:0] e_raw;
   logic [MAN_W:0]          m_rnd;
   logic [EXP_W-1:0]        e_fin;
   logic                    rup;
   logic                    unused_bits;

   // Highest set bit wins, so the last match in the loop is kept.
   always_comb begin
      lzc = LZW'(W);
      for (int i = 0; i < W; i++) begin
         if (d[i]) lzc = LZW'(W - 1 - i);
      end
   end

   assign n = d << lzc;

   assign e_raw = $signed({2'b00, exp_in})
                - $signed({{(EXP_W + 2 - LZW){1'b0}}, lzc});

`ifdef FP_CSUB_RNE_EN
   assign rup = n[GRD_W-1]
              & ((|n[GRD_W-2:0]) | n[GRD_W]);
   assign unused_bits = n[W-1];
`else
   assign rup = 1'b0;
   assign unused_bits = ^{n[W-1], n[GRD_W-1:0]};
`endif

   // A carry out of the mantissa leaves it zero and bumps exp.
   assign m_rnd = {1'b0, n[W-2:GRD_W]} + (MAN_W + 1)'(rup);
   assign e_fin = e_raw[EXP_W-1:0] + EXP_W'(m_rnd[MAN_W]);

   always_comb begin
      res = '0;
      if (!kill && !e_raw[EXP_W+1] && e_raw != '0) begin
         res = {e_fin, m_rnd[MAN_W-1:0]};
      end
   end

endmodule

// File: rtl/fp_const_sub_pipe.sv
// Two-stage pipelined R = C - x with valid/ready and sideband.
// Rounding mode selected by FP_CSUB_RNE_EN (truncate when undefined).
module fp_const_sub_pipe
   import fp_pkg::*;
#(
   parameter int               EXP_W = EXP_W_D,
   parameter int               MAN_W = MAN_W_D,
   parameter int               GRD_W = GRD_W_D,
   parameter int               DLY_W = DLY_W_D,
   parameter logic [EXP_W-1:0] C_EXP = C_EXP_D,
   parameter logic [MAN_W-1:0] C_MAN = C_MAN_D
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W-1:0] float_in,
   input  logic [DLY_W-1:0]       float_in_delay,
   input  logic                   error_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W-1:0] float_out,
   output logic [DLY_W-1:0]       float_out_delay,
   output logic                   error_out
);

   localparam int W = MAN_W + GRD_W + 1;
   localparam logic [W-1:0] CV = {1'b1, C_MAN, {GRD_W{1'b0}}};

   typedef struct packed {
      logic [W-1:0]     d;
      logic             sp_flag;
      logic             err;
      logic             ein;
      logic [EXP_W-1:0] exp;
      logic [DLY_W-1:0] dly;
   } s1_t;

   logic v1, v2, adv1, adv2, kill;
   s1_t  s1_d, s1_q;

   logic [EXP_W-1:0]       x_exp;
   logic [MAN_W-1:0]       x_man;
   logic [W-1:0]           xv, al, mask;
   logic [EXP_W+MAN_W-1:0] nr_res;
   int                     sh;

   assign adv2      = ~v2 | out_ready;
   assign adv1      = ~v1 | adv2;
   assign in_ready  = adv1;
   assign out_valid = v2;

   assign {x_exp, x_man} = float_in;
   assign xv = {1'b1, x_man, {GRD_W{1'b0}}};

   always_comb begin
      s1_d = '0;
      al   = '0;
      mask = '0;
      sh   = 0;
      if (x_exp == '0) begin
         al = '0;
      end else if (&x_exp) begin
         s1_d.sp_flag = 1'b1;
         s1_d.err     = 1'b1;
      end else if (x_exp > C_EXP ||
                   (x_exp == C_EXP && x_man >= C_MAN)) begin
         s1_d.err = 1'b1;
      end else begin
         sh = int'(C_EXP) - int'(x_exp);
         if (sh >= W) begin
            al = W'(1);
         end else begin
            // Bits shifted past the LSB collapse into the sticky bit.
            mask  = ~({W{1'b1}} << sh);
            al    = xv >> sh;
            al[0] = al[0] | (|(xv & mask));
         end
      end
      s1_d.d   = CV - al;
      s1_d.ein = error_in;
      s1_d.exp = C_EXP;
      s1_d.dly = float_in_delay;
   end

   assign kill = s1_q.err | s1_q.sp_flag | (s1_q.d == '0);

   fp_norm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W),
      .GRD_W (GRD_W)
   ) u_nr (
      .d      (s1_q.d),
      .exp_in (s1_q.exp),
      .kill   (kill),
      .res    (nr_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1              <= 1'b0;
         v2              <= 1'b0;
         s1_q            <= '0;
         float_out       <= '0;
         float_out_delay <= '0;
         error_out       <= 1'b0;
      end else begin
         if (adv1) begin
            v1 <= in_valid;
            if (in_valid) s1_q <= s1_d;
         end
         if (adv2) begin
            v2 <= v1;
            if (v1) begin
               float_out       <= nr_res;
               float_out_delay <= s1_q.dly;
               error_out       <= s1_q.ein | kill;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_const_sub_pipe.sv
// Directed self-checking bench for fp_const_sub_pipe.
// Rounding expectation follows FP_CSUB_RNE_EN.
module tb_fp_const_sub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [30:0] float_in = '0;
   logic [30:0] float_in_delay = '0;
   logic        error_in = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [30:0] float_out;
   logic [30:0] float_out_delay;
   logic        error_out;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp_const_sub_pipe dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .float_in        (float_in),
      .float_in_delay  (float_in_delay),
      .error_in        (error_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .float_out       (float_out),
      .float_out_delay (float_out_delay),
      .error_out       (error_out)
   );

   task automatic run_one(input logic [30:0] x,
                          input logic [30:0] dl,
                          input logic ei,
                          output logic [30:0] r,
                          output logic [30:0] rd,
                          output logic re,
                          output int lat);
      int k;
      r = '0; rd = '0; re = 1'b0; lat = 99;
      @(negedge clk);
      float_in = x; float_in_delay = dl; error_in = ei;
      in_valid = 1'b1; out_ready = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) in_valid = 1'b0;
         if (out_valid) begin
            lat = c; r = float_out;
            rd = float_out_delay; re = error_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || float_out !== '0 ||
          float_out_delay !== '0 || error_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs: v=%b f=%h d=%h e=%b want 0",
                  out_valid, float_out, float_out_delay, error_out);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [30:0] r, rd; logic re; int lat;
      run_one(31'h3F000000, 31'h12345678, 1'b0, r, rd, re, lat);
      checks += 4;
      if (r !== 31'h3F800000) begin
         failures++;
         $display("FAIL half_res: got %h want 3f800000", r);
      end
      if (re !== 1'b0) begin
         failures++;
         $display("FAIL half_err: got %b want 0", re);
      end
      if (rd !== 31'h12345678) begin
         failures++;
         $display("FAIL half_dly: got %h want 12345678", rd);
      end
      if (lat != 2) begin
         failures++;
         $display("FAIL half_lat: got %0d want 2", lat);
      end
   endtask

   task automatic test_specials();
      logic [30:0] xs [3];
      logic [30:0] r, rd; logic re; int lat;
      xs[0] = 31'h3FC00000;
      xs[1] = 31'h40000000;
      xs[2] = 31'h7F800000;
      for (int i = 0; i < 3; i++) begin
         run_one(xs[i], 31'(i), 1'b0, r, rd, re, lat);
         checks += 2;
         if (r !== '0) begin
            failures++;
            $display("FAIL special_res[%0d]: got %h want 0", i, r);
         end
         if (re !== 1'b1) begin
            failures++;
            $display("FAIL special_err[%0d]: got %b want 1", i, re);
         end
      end
      run_one(31'h0, 31'h7, 1'b0, r, rd, re, lat);
      checks += 2;
      if (r !== 31'h3FC00000) begin
         failures++;
         $display("FAIL zero_res: got %h want 3fc00000", r);
      end
      if (re !== 1'b0) begin
         failures++;
         $display("FAIL zero_err: got %b want 0", re);
      end
   endtask

   task automatic test_round();
      logic [30:0] r, rd, want; logic re; int lat;
`ifdef FP_CSUB_RNE_EN
      want = 31'h3FC00000;
`else
      want = 31'h3FBFFFFF;
`endif
      run_one(31'h30800000, 31'h9, 1'b0, r, rd, re, lat);
      checks += 2;
      if (r !== want) begin
         failures++;
         $display("FAIL round_res: got %h want %h", r, want);
      end
      if (re !== 1'b0) begin
         failures++;
         $display("FAIL round_err: got %b want 0", re);
      end
   endtask

   task automatic test_error_in();
      logic [30:0] r, rd; logic re; int lat;
      run_one(31'h3F000000, 31'h21, 1'b1, r, rd, re, lat);
      checks += 2;
      if (r !== 31'h3F800000) begin
         failures++;
         $display("FAIL ein_res: got %h want 3f800000", r);
      end
      if (re !== 1'b1) begin
         failures++;
         $display("FAIL ein_err: got %b want 1", re);
      end
      run_one(31'h3F000000, 31'h22, 1'b0, r, rd, re, lat);
      checks++;
      if (re !== 1'b0) begin
         failures++;
         $display("FAIL ein_next_err: got %b want 0", re);
      end
   endtask

   task automatic test_back_to_back();
      logic [30:0] xs [8];
      logic [30:0] es [8];
      logic [30:0] hv, hd;
      logic held, saw_low;
      int i, j, extra;
      xs[0] = 31'h00000000; es[0] = 31'h3FC00000;
      xs[1] = 31'h3F000000; es[1] = 31'h3F800000;
      xs[2] = 31'h3F800000; es[2] = 31'h3F000000;
      xs[3] = 31'h3E800000; es[3] = 31'h3FA00000;
      xs[4] = 31'h3FA00000; es[4] = 31'h3E800000;
      xs[5] = 31'h3F400000; es[5] = 31'h3F400000;
      xs[6] = 31'h3E000000; es[6] = 31'h3FB00000;
      xs[7] = 31'h3F800000; es[7] = 31'h3F000000;
      i = 0; j = 0; extra = 0;
      held = 1'b0; saw_low = 1'b0; hv = '0; hd = '0;
      error_in = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || float_out !== hv ||
                float_out_delay !== hd) begin
               failures++;
               $display("FAIL hold: v=%b f=%h d=%h want 1 %h %h",
                        out_valid, float_out, float_out_delay, hv, hd);
            end
         end
         out_ready = !(cyc >= 4 && cyc <= 6);
         if (i < 8) begin
            in_valid = 1'b1;
            float_in = xs[i];
            float_in_delay = 31'(100 + i);
         end else begin
            in_valid = 1'b0;
         end
         #4;
         if (!in_ready) saw_low = 1'b1;
         held = out_valid && !out_ready;
         hv = float_out;
         hd = float_out_delay;
         if (out_valid && out_ready) begin
            if (j < 8) begin
               checks += 2;
               if (float_out !== es[j]) begin
                  failures++;
                  $display("FAIL b2b_res[%0d]: got %h want %h",
                           j, float_out, es[j]);
               end
               if (float_out_delay !== 31'(100 + j)) begin
                  failures++;
                  $display("FAIL b2b_dly[%0d]: got %0d want %0d",
                           j, float_out_delay, 100 + j);
               end
            end else begin
               extra++;
            end
            j++;
         end
         if (in_valid && in_ready) i++;
      end
      in_valid = 1'b0;
      checks += 3;
      if (j != 8 || extra != 0) begin
         failures++;
         $display("FAIL b2b_count: got %0d want 8", j);
      end
      if (i != 8) begin
         failures++;
         $display("FAIL b2b_accepted: got %0d want 8", i);
      end
      if (!saw_low) begin
         failures++;
         $display("FAIL b2b_in_ready_low: got %b want 1", saw_low);
      end
   endtask

   task automatic test_reset_midflight();
      logic [30:0] r, rd; logic re; int lat; int seen;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; float_in = 31'h3F000000; float_in_delay = 31'h1;
      @(negedge clk);
      float_in = 31'h3F800000; float_in_delay = 31'h2;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_full: v=%b rdy=%b want 1 0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_rst_now: v=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL mid_ghost: got %0d outputs want 0", seen);
      end
      run_one(31'h3F000000, 31'h55, 1'b0, r, rd, re, lat);
      checks += 3;
      if (lat != 2) begin
         failures++;
         $display("FAIL mid_post_lat: got %0d want 2", lat);
      end
      if (r !== 31'h3F800000) begin
         failures++;
         $display("FAIL mid_post_res: got %h want 3f800000", r);
      end
      if (rd !== 31'h55) begin
         failures++;
         $display("FAIL mid_post_dly: got %h want 55", rd);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_specials();
      test_round();
      test_error_in();
      test_back_to_back();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
